// File: rtl/add_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error profiler.
// The widths are chosen so that a full operand sweep cannot overflow any accumulator.
package add_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } prof_state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int abs_w(input int w);
    return 3 * w + 1;
  endfunction

  function automatic int sq_w(input int w);
    return 4 * w + 2;
  endfunction

endpackage

// File: rtl/err_accum.sv
// Second pipeline stage: computes the error magnitude of one captured sum pair.
// Folds that error into the running statistics.
module err_accum
  import add_eval_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  valid,
  input  logic [sum_w(W)-1:0]   exact,
  input  logic [sum_w(W)-1:0]   approx,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  output logic [cnt_w(W)-1:0]   err_cnt,
  output logic [sum_w(W)-1:0]   wce,
  output logic [W-1:0]          wce_a,
  output logic [W-1:0]          wce_b,
  output logic [abs_w(W)-1:0]   sum_abs_err,
  output logic [sq_w(W)-1:0]    sum_sq_err
);

  localparam int SW = sum_w(W);
  localparam int CW = cnt_w(W);
  localparam int AW = abs_w(W);
  localparam int QW = sq_w(W);
  localparam int PW = 2 * SW;

  logic [SW:0]   diff;
  logic [SW:0]   neg;
  logic [SW-1:0] err;
  logic [PW-1:0] err_x;
  logic [PW-1:0] sq;

  // One extra bit keeps the sign so over- and under-estimates both fold correctly
  always_comb begin
    diff  = {1'b0, exact} - {1'b0, approx};
    neg   = -diff;
    err   = diff[SW] ? neg[SW-1:0] : diff[SW-1:0];
    err_x = {{SW{1'b0}}, err};
    sq    = err_x * err_x;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt     <= '0;
      wce         <= '0;
      wce_a       <= '0;
      wce_b       <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
    end else if (valid) begin
      err_cnt     <= err_cnt + CW'(err != '0);
      sum_abs_err <= sum_abs_err + AW'(err);
      sum_sq_err  <= sum_sq_err + QW'(sq);
      // Strict compare keeps the earliest pair on ties
      if (err > wce) begin
        wce   <= err;
        wce_a <= a;
        wce_b <= b;
      end
    end
  end

endmodule

// File: rtl/add8u_err_profiler.sv
// Exhaustive error profiler for unsigned approximate adders.
// It sweeps every operand pair, captures the DUT sum and accumulates error statistics.
module add8u_err_profiler
  import add_eval_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [W-1:0]          dut_a,
  output logic [W-1:0]          dut_b,
  input  logic [sum_w(W)-1:0]   dut_o,
  output logic                  busy,
  output logic                  done,
  output logic [cnt_w(W)-1:0]   err_cnt,
  output logic [sum_w(W)-1:0]   wce,
  output logic [W-1:0]          wce_a,
  output logic [W-1:0]          wce_b,
  output logic [abs_w(W)-1:0]   sum_abs_err,
  output logic [sq_w(W)-1:0]    sum_sq_err
);

  localparam int SW = sum_w(W);
  localparam int IW = 2 * W;
  localparam int DW = 2;

  prof_state_t   state;
  prof_state_t   state_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] drain_n;
  logic          clr;
  logic          done_n;

  logic          s1_v;
  logic [SW-1:0] s1_o;
  logic [SW-1:0] s1_e;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;

  assign dut_a = idx[W-1:0];
  assign dut_b = idx[IW-1:W];
  assign busy  = (state == SWEEP) || (state == DRAIN);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    drain_n = drain_cnt;
    clr     = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SWEEP;
          idx_n   = '0;
          clr     = 1'b1;
        end
      end
      SWEEP: begin
        idx_n = idx + 1'b1;
        if (&idx) begin
          state_n = DRAIN;
          drain_n = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          drain_n = drain_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      drain_cnt <= drain_n;
      done      <= done_n;
    end
  end

  // Stage 1: capture the pair presented this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_o <= '0;
      s1_e <= '0;
      s1_a <= '0;
      s1_b <= '0;
    end else begin
      s1_v <= (state == SWEEP);
      s1_o <= dut_o;
      s1_e <= {1'b0, dut_a} + {1'b0, dut_b};
      s1_a <= dut_a;
      s1_b <= dut_b;
    end
  end

  err_accum #(
    .W (W)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .valid       (s1_v),
    .exact       (s1_e),
    .approx      (s1_o),
    .a           (s1_a),
    .b           (s1_b),
    .err_cnt     (err_cnt),
    .wce         (wce),
    .wce_a       (wce_a),
    .wce_b       (wce_b),
    .sum_abs_err (sum_abs_err),
    .sum_sq_err  (sum_sq_err)
  );

endmodule

// File: tb/tb_add8u_err_profiler.sv
// Self-checking bench for add8u_err_profiler at a reduced width to keep sweeps short.
// The expected statistics come from a plain nested-loop model of the whole sweep.
module tb_add8u_err_profiler;

  localparam int W  = 4;
  localparam int NA = 1 << W;
  localparam int N  = 1 << (2 * W);
  localparam int SW = W + 1;
  localparam int CW = 2 * W + 1;
  localparam int AW = 3 * W + 1;
  localparam int QW = 4 * W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  dut_a;
  logic [W-1:0]  dut_b;
  logic [SW-1:0] dut_o;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_cnt;
  logic [SW-1:0] wce;
  logic [W-1:0]  wce_a;
  logic [W-1:0]  wce_b;
  logic [AW-1:0] sum_abs_err;
  logic [QW-1:0] sum_sq_err;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  logic [SW-1:0] rtab [N];
  logic [SW-1:0] ex_sum;

  longint m_cnt, m_abs, m_sq;
  int     m_wce, m_wa, m_wb;

  always #5 clk = ~clk;

  // Behavioural adders under test, selected by mode
  assign ex_sum = {1'b0, dut_a} + {1'b0, dut_b};
  assign dut_o = (mode == 0) ? ex_sum :
                 (mode == 1) ? {ex_sum[SW-1:1], 1'b0} :
                 (mode == 2) ? '0 :
                 (mode == 3) ? '1 :
                 rtab[{dut_b, dut_a}];

  add8u_err_profiler #(
    .W (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dut_a       (dut_a),
    .dut_b       (dut_b),
    .dut_o       (dut_o),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt),
    .wce         (wce),
    .wce_a       (wce_a),
    .wce_b       (wce_b),
    .sum_abs_err (sum_abs_err),
    .sum_sq_err  (sum_sq_err)
  );

  task automatic model_run();
    int e, ap, er;
    m_cnt = 0; m_abs = 0; m_sq = 0;
    m_wce = 0; m_wa = 0; m_wb = 0;
    for (int b = 0; b < NA; b++) begin
      for (int a = 0; a < NA; a++) begin
        e = a + b;
        case (mode)
          0: ap = e;
          1: ap = e - (e % 2);
          2: ap = 0;
          3: ap = (1 << SW) - 1;
          default: ap = int'(rtab[b * NA + a]);
        endcase
        er = (ap > e) ? ap - e : e - ap;
        if (er != 0) m_cnt++;
        m_abs += er;
        m_sq  += longint'(er) * er;
        if (er > m_wce) begin
          m_wce = er; m_wa = a; m_wb = b;
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 2) == 0)
        rtab[k] = SW'($urandom_range(0, (1 << SW) - 1));
      else
        rtab[k] = SW'((k % NA) + (k / NA));
    end
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int cyc, output bit gap);
    cyc = 0;
    gap = 1'b0;
    while (done !== 1'b1 && cyc < N + 20) begin
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) gap = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dut_a, dut_b, busy, done, err_cnt, wce, wce_a, wce_b, sum_abs_err, sum_sq_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a=%0d b=%0d busy=%b done=%b cnt=%0d wce=%0d abs=%0d sq=%0d, required all 0",
               dut_a, dut_b, busy, done, err_cnt, wce, sum_abs_err, sum_sq_err);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || dut_a !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b a=%0d, required 0 0", busy, dut_a);
    end
  endtask

  task automatic test_fixed_duts();
    int cyc;
    bit gap;
    for (int m = 0; m < 4; m++) begin
      mode = m;
      model_run();
      launch();
      wait_done(1'b0, cyc, gap);
      checks++;
      if (err_cnt !== CW'(m_cnt) || wce !== SW'(m_wce) || wce_a !== W'(m_wa) ||
          wce_b !== W'(m_wb) || sum_abs_err !== AW'(m_abs) || sum_sq_err !== QW'(m_sq)) begin
        errors++;
        $display("FAIL fixed_stats mode%0d: got cnt=%0d wce=%0d@(%0d,%0d) abs=%0d sq=%0d, want cnt=%0d wce=%0d@(%0d,%0d) abs=%0d sq=%0d",
                 m, err_cnt, wce, wce_a, wce_b, sum_abs_err, sum_sq_err,
                 m_cnt, m_wce, m_wa, m_wb, m_abs, m_sq);
      end
    end
  endtask

  task automatic test_random_duts();
    int cyc;
    bit gap;
    mode = 4;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      model_run();
      launch();
      wait_done(1'b0, cyc, gap);
      checks++;
      if (err_cnt !== CW'(m_cnt) || wce !== SW'(m_wce) || wce_a !== W'(m_wa) ||
          wce_b !== W'(m_wb) || sum_abs_err !== AW'(m_abs) || sum_sq_err !== QW'(m_sq)) begin
        errors++;
        $display("FAIL random_stats run%0d: got cnt=%0d wce=%0d@(%0d,%0d) abs=%0d sq=%0d, want cnt=%0d wce=%0d@(%0d,%0d) abs=%0d sq=%0d",
                 r, err_cnt, wce, wce_a, wce_b, sum_abs_err, sum_sq_err,
                 m_cnt, m_wce, m_wa, m_wb, m_abs, m_sq);
      end
    end
  endtask

  task automatic test_timing();
    int cyc;
    bit gap;
    mode = 4;
    fill_random();
    model_run();
    launch();
    checks++;
    if (busy !== 1'b1 || dut_a !== '0 || dut_b !== '0) begin
      errors++;
      $display("FAIL first_cycle: busy=%b a=%0d b=%0d, required 1 0 0", busy, dut_a, dut_b);
    end
    wait_done(1'b1, cyc, gap);
    checks++;
    if (cyc != N + 2) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles, required %0d", cyc, N + 2);
    end
    checks++;
    if (gap || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_window: gap=%b busy_at_done=%b, required 0 0", gap, busy);
    end
    checks++;
    if (err_cnt !== CW'(m_cnt) || wce !== SW'(m_wce) || wce_a !== W'(m_wa) ||
        wce_b !== W'(m_wb) || sum_abs_err !== AW'(m_abs) || sum_sq_err !== QW'(m_sq)) begin
      errors++;
      $display("FAIL noisy_stats: got cnt=%0d wce=%0d abs=%0d sq=%0d, want cnt=%0d wce=%0d abs=%0d sq=%0d",
               err_cnt, wce, sum_abs_err, sum_sq_err, m_cnt, m_wce, m_abs, m_sq);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum_sq_err !== QW'(m_sq) || err_cnt !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL done_hold: done=%b busy=%b cnt=%0d sq=%0d, want 0 0 %0d %0d",
                 done, busy, err_cnt, sum_sq_err, m_cnt, m_sq);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit gap;
    mode = 2;
    launch();
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({dut_a, dut_b, busy, done, err_cnt, wce, wce_a, wce_b, sum_abs_err, sum_sq_err} !== '0) begin
      errors++;
      $display("FAIL midreset_zero: a=%0d b=%0d busy=%b cnt=%0d wce=%0d abs=%0d, required all 0",
               dut_a, dut_b, busy, err_cnt, wce, sum_abs_err);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || err_cnt !== '0 || sum_abs_err !== '0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b cnt=%0d abs=%0d, required 0 0 0", busy, err_cnt, sum_abs_err);
    end
    model_run();
    launch();
    wait_done(1'b0, cyc, gap);
    checks++;
    if (err_cnt !== CW'(m_cnt) || wce !== SW'(m_wce) || wce_a !== W'(m_wa) ||
        wce_b !== W'(m_wb) || sum_abs_err !== AW'(m_abs) || sum_sq_err !== QW'(m_sq) || cyc != N + 2) begin
      errors++;
      $display("FAIL midreset_rerun: got cyc=%0d cnt=%0d wce=%0d abs=%0d sq=%0d, want cyc=%0d cnt=%0d wce=%0d abs=%0d sq=%0d",
               cyc, err_cnt, wce, sum_abs_err, sum_sq_err, N + 2, m_cnt, m_wce, m_abs, m_sq);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit gap;
    mode = 2;
    launch();
    wait_done(1'b0, cyc, gap);
    mode = 1;
    model_run();
    launch();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== '0 || wce !== '0 || sum_sq_err !== '0) begin
      errors++;
      $display("FAIL restart_clear: busy=%b done=%b cnt=%0d wce=%0d sq=%0d, required 1 0 0 0 0",
               busy, done, err_cnt, wce, sum_sq_err);
    end
    wait_done(1'b0, cyc, gap);
    checks++;
    if (err_cnt !== CW'(m_cnt) || wce !== SW'(m_wce) || wce_a !== W'(m_wa) ||
        wce_b !== W'(m_wb) || sum_abs_err !== AW'(m_abs) || sum_sq_err !== QW'(m_sq) || cyc != N + 2) begin
      errors++;
      $display("FAIL restart_stats: got cyc=%0d cnt=%0d wce=%0d@(%0d,%0d) abs=%0d, want cyc=%0d cnt=%0d wce=%0d@(%0d,%0d) abs=%0d",
               cyc, err_cnt, wce, wce_a, wce_b, sum_abs_err, N + 2, m_cnt, m_wce, m_wa, m_wb, m_abs);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_fixed_duts();
    test_random_duts();
    test_timing();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add8u_err_profiler.md
# add8u_err_profiler

Exhaustive error-characterisation stage for 8-bit unsigned approximate adders. It drives every operand pair into an adder under test (DUT) and consumes the DUT's 9-bit sum. It compares each sum against the exact sum and accumulates error statistics (error count, worst-case error, sum of absolute errors, sum of squared errors). These figures feed the MAE/WCE/EP/MSE columns of the library's characterisation flow and its LUT generation.

## Interface
Parameters:
- `W`, 8, operand width; DUT sum is `W+1` bits; sweep covers 2^(2W) pairs

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE
- `dut_a`  out  W  operand A to DUT (registered)
- `dut_b`  out  W  operand B to DUT (registered)
- `dut_o`  in  W+1  DUT sum, combinational from `dut_a`/`dut_b`
- `busy`  out  1  high in SWEEP and DRAIN
- `done`  out  1  one-cycle pulse on sweep completion
- `err_cnt`  out  2W+1  number of pairs with `dut_o` ≠ exact sum
- `wce`  out  W+1  maximum |error|
- `wce_a`, `wce_b`  out  W each  first pair, in sweep order, that reached `wce`
- `sum_abs_err`  out  3W+1  Σ|error|
- `sum_sq_err`  out  4W+2  Σerror²

## Operation
- States: IDLE, SWEEP, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE with `start`=1:
  - go to SWEEP.
  - Clear the pair index `idx` (2W bits) and all statistic outputs.
- SWEEP:
  - `dut_a` = `idx[W-1:0]` and `dut_b` = `idx[2W-1:W]`, so A varies fastest.
  - `idx` increments every cycle.
  - When `idx` = all-ones is presented, the next state is DRAIN and `idx` wraps to 0.
- DRAIN: lasts exactly 2 cycles while the pipeline empties, then DONE.
- DONE:
  - `done` is high for its first cycle only.
  - Statistics hold until the next accepted `start` or `rst`.
- `start` in SWEEP or DRAIN is ignored; the sweep is not restarted.
- Pipeline:
  - Stage 1 registers `dut_o`, the exact sum `dut_a+dut_b` (W+1 bits, no overflow), and the operands.
  - Stage 2 computes the error as the absolute difference of (W+1)-bit unsigned values. The difference is formed in W+2 bits before taking the magnitude, so both overestimation and underestimation are handled.
  - Stage 2 then updates the statistics:
    - `err_cnt` += (err≠0)
    - `sum_abs_err` += err
    - `sum_sq_err` += err²
    - if err > `wce`: load `wce`, `wce_a`, `wce_b`. The comparison is strict, so the earliest pair wins ties.
- Accumulator widths are sized so they cannot overflow for a full sweep. No saturation logic is needed.
- `rst` mid-sweep:
  - Abandon the sweep and flush the pipeline valid bits.
  - Go to IDLE.
  - No partial results survive.

## Timing
- Reset values: all outputs 0, including `dut_a`, `dut_b`, `busy`, `done` and every statistic.
- Start edge e0 (`start` sampled high):
  - `busy`=1 from the next cycle.
  - Pair 0 is presented in the cycle after e0.
- Pair k is presented during the cycle following edge e0+k and captured at edge e0+k+1. Its statistics update at edge e0+k+2.
- The last pair (k = 2^(2W)−1) is accumulated at edge e0+2^(2W)+1.
- At edge e0+2^(2W)+2:
  - state becomes DONE.
  - `done`=1 and `busy`=0.
  - For W=8 this is 65538 cycles after the start edge.
- Statistics are final and stable whenever `done` is high and throughout DONE.
- `start` asserted in the DONE cycle where `done`=1:
  - the new sweep is accepted.
  - statistics clear at that edge.

## Structure
- Package `add_eval_pkg`:
  - state enum `prof_state_t` (IDLE, SWEEP, DRAIN, DONE).
  - width localparam functions for the sum, count, abs-sum and square-sum widths as functions of W.
  - `DRAIN_CYCLES` = 2.
- Sub-module `err_accum`: stage 2 only.
  - Inputs: the valid bit, the exact/approx sum pair, the operands, and a clear.
  - Outputs: the statistic registers.
- The top level holds the FSM, the index counter, operand registers and stage-1 registers.

## Test plan
- Exact DUT (`dut_o`=A+B): `err_cnt`=0, `wce`=0, `sum_abs_err`=0, `sum_sq_err`=0.
- DUT = exact sum with bit 0 forced to 0:
  - `err_cnt`=32768, `sum_abs_err`=32768, `sum_sq_err`=32768.
  - `wce`=1, `wce_a`=1, `wce_b`=0.
- DUT stuck at 0:
  - `err_cnt`=65535, `wce`=510, `wce_a`=`wce_b`=255.
  - `sum_abs_err`=16711680, `sum_sq_err`=4977295360.
- DUT constant 9'h1FF (overestimating):
  - `wce`=511, `wce_a`=`wce_b`=0.
  - `err_cnt`=65536, `sum_abs_err`=16777216.
- Timing check with any DUT: start at edge e0 gives `done` as a single-cycle pulse at e0+65538, `busy` low only in that cycle and after. `start` pulses during SWEEP change neither the timing nor the results.
- Reset mid-sweep: `rst` at idx 1000 gives all outputs 0 and state IDLE on the next cycle. A following `start` produces results identical to a clean run of the same DUT.
